// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD controller: FSM state encoding and the
// iteration ceiling used by the saturating step counter.
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CMP  = 3'd2,
        SUBX = 3'd3,
        SUBY = 3'd4,
        DONE = 3'd5
    } gcd_state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // MAX_ITER(WIDTH) = 2**WIDTH, the value at which the step counter sticks.
    function automatic int unsigned max_iter(input int unsigned width);
        return 32'd1 << width;
    endfunction

endpackage

// File: rtl/gcd_iter_counter.sv
// Saturating subtraction-step counter: synchronous clear, increment, and a
// flag that goes high once the count reaches 2**WIDTH.
module gcd_iter_counter
    import gcd_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH:0]   count,
    output logic             sat
);

    localparam logic [WIDTH:0] CNT_MAX = (WIDTH+1)'(max_iter(WIDTH));

    logic [WIDTH:0] count_reg;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && !sat) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign sat   = (count_reg == CNT_MAX);
    assign count = count_reg;

endmodule

// File: rtl/gcd_controller.sv
// Moore FSM sequencing a subtract-and-compare GCD datapath.
// Optional build macro GCD_CTRL_TIMEOUT_EN ends a run with err=1 once the step count saturates.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             eq,
    input  logic             lt,
    output logic             x_load,
    output logic             y_load,
    output logic             x_select,
    output logic             y_select,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH:0]   iters
);

    gcd_state_t state_reg, state_next;
    logic       iter_clear;
    logic       iter_inc;
    logic       iter_sat;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

`ifdef GCD_CTRL_TIMEOUT_EN
    logic err_reg, err_next;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        x_load     = 1'b0;
        y_load     = 1'b0;
        x_select   = 1'b0;
        y_select   = 1'b0;
        iter_clear = 1'b0;
        iter_inc   = 1'b0;
`ifdef GCD_CTRL_TIMEOUT_EN
        err_next   = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                x_load     = 1'b1;
                y_load     = 1'b1;
                x_select   = 1'b1;
                y_select   = 1'b1;
                iter_clear = 1'b1;
`ifdef GCD_CTRL_TIMEOUT_EN
                err_next   = 1'b0;
`endif
                state_next = CMP;
            end
            CMP: begin
                if (eq) begin
                    state_next = DONE;
`ifdef GCD_CTRL_TIMEOUT_EN
                end else if (iter_sat) begin
                    // A zero operand never converges; give up with an error.
                    state_next = DONE;
                    err_next   = 1'b1;
`endif
                end else if (lt) begin
                    state_next = SUBY;
                end else begin
                    state_next = SUBX;
                end
            end
            SUBX: begin
                x_load     = 1'b1;
                iter_inc   = 1'b1;
                state_next = CMP;
            end
            SUBY: begin
                y_load     = 1'b1;
                iter_inc   = 1'b1;
                state_next = CMP;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    gcd_iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter_counter (
        .clk   (clk),
        .clr   (clr),
        .clear (iter_clear),
        .inc   (iter_inc && !iter_sat),
        .count (iters),
        .sat   (iter_sat)
    );

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: behavioural datapath plus a per-cycle expected-output
// schedule derived from repeated-subtraction arithmetic.
module tb_gcd_controller;

    localparam int W    = 4;
    localparam int MAXI = 1 << W;
`ifdef GCD_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic         eq, lt;
    logic         x_load, y_load, x_select, y_select;
    logic         busy, done, err;
    logic [W:0]   iters;
    logic [W-1:0] x_in = '0, y_in = '0;
    logic [W-1:0] x_dp = '0, y_dp = '0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit xl, yl, xs, ys, bsy, dn, chk;
        int it;
        bit e;
    } exp_t;
    exp_t exp_q[$];

    gcd_controller #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .eq       (eq),
        .lt       (lt),
        .x_load   (x_load),
        .y_load   (y_load),
        .x_select (x_select),
        .y_select (y_select),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .iters    (iters)
    );

    always #5 clk = ~clk;

    // Datapath being controlled
    always @(posedge clk) begin
        if (x_load) x_dp <= x_select ? x_in : x_dp - y_dp;
        if (y_load) y_dp <= y_select ? y_in : y_dp - x_dp;
    end
    assign eq = (x_dp == y_dp);
    assign lt = (x_dp < y_dp);

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit xl, yl, xs, ys, bsy, dn, chk, input int it, input bit e);
        exp_t t;
        t.xl = xl; t.yl = yl; t.xs = xs; t.ys = ys;
        t.bsy = bsy; t.dn = dn; t.chk = chk; t.it = it; t.e = e;
        exp_q.push_back(t);
    endtask

    // Reference: Euclid by subtraction; one LOAD, a compare before each step,
    // a subtraction per step, then a done cycle.
    task automatic model_sched(input int x, input int y, output int k, output bit e,
                               output int ncyc);
        int a, b, n0;
        a = x; b = y; k = 0; e = 1'b0;
        n0 = exp_q.size();
        push(1, 1, 1, 1, 1, 0, 0, 0, 0);
        for (int g = 0; g < 1000; g++) begin
            push(0, 0, 0, 0, 1, 0, 0, 0, 0);
            if (a == b) break;
            if (TIMEOUT && k == MAXI) begin
                e = 1'b1;
                break;
            end
            if (a < b) begin
                push(0, 1, 0, 0, 1, 0, 0, 0, 0);
                b = b - a;
            end else begin
                push(1, 0, 0, 0, 1, 0, 0, 0, 0);
                a = a - b;
            end
            k++;
        end
        push(0, 0, 0, 0, 1, 1, 1, k, e);
        ncyc = exp_q.size() - n0;
    endtask

    always @(negedge clk) begin
        exp_t t;
        if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            check("ctrl", int'({x_load, y_load, x_select, y_select, busy, done}),
                  int'({t.xl, t.yl, t.xs, t.ys, t.bsy, t.dn}));
            if (t.chk) begin
                check("iters", int'(iters), t.it);
                check("err", int'(err), int'(t.e));
            end
        end
    end

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) @(posedge clk);
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_gcd(input int x, input int y, input int lit_cyc, input int lit_it,
                           input int lit_err);
        int k, ncyc, cyc;
        bit e, got;
        @(posedge clk); #1;
        x_in = W'(x); y_in = W'(y); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_sched(x, y, k, e, ncyc);
        push(0, 0, 0, 0, 0, 0, 1, k, e);
        push(0, 0, 0, 0, 0, 0, 1, k, e);
        if (lit_cyc >= 0) begin
            check("model_cycles", ncyc, lit_cyc);
            check("model_iters", k, lit_it);
            check("model_err", int'(e), lit_err);
        end
        cyc = 0; got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
        end
        check("done_cycle", got ? cyc : -1, ncyc);
        drain(20);
    endtask

    initial begin
        int k, ncyc;
        bit e, seen;
        clr = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs", int'({x_load, y_load, x_select, y_select, busy, done, err}), 0);
        check("rst_iters", int'(iters), 0);
        @(posedge clk); #1 clr = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outs", int'({x_load, y_load, x_select, y_select, busy, done, err}), 0);

        run_gcd(12, 8, 7, 2, 0);
        run_gcd(7, 7, 3, 0, 0);
        run_gcd(1, 15, 31, 14, 0);

`ifdef GCD_CTRL_TIMEOUT_EN
        run_gcd(0, 5, 35, 16, 1);
`else
        @(posedge clk); #1;
        x_in = 4'd0; y_in = 4'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("zero_busy", int'(busy), 1);
        check("zero_done_seen", int'(seen), 0);
        check("zero_iters_sat", int'(iters), MAXI);
        #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
`endif

        // Asynchronous clear in the middle of a SUBX cycle
        @(posedge clk); #1;
        x_in = 4'd12; y_in = 4'd8; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("subx_xload", int'({x_load, x_select, busy}), 3'b101);
        #1 clr = 1'b1;
        #1;
        check("clr_outs", int'({x_load, y_load, x_select, y_select, busy, done, err}), 0);
        check("clr_iters", int'(iters), 0);
        @(posedge clk); #1 clr = 1'b0;
        run_gcd(12, 8, 7, 2, 0);

        // start held high: back-to-back runs with one idle cycle between
        @(posedge clk); #1;
        x_in = 4'd12; y_in = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        model_sched(12, 8, k, e, ncyc);
        push(0, 0, 0, 0, 0, 0, 1, k, e);
        model_sched(12, 8, k, e, ncyc);
        push(0, 0, 0, 0, 0, 0, 1, k, e);
        push(0, 0, 0, 0, 0, 0, 1, k, e);
        repeat (ncyc + 1) @(posedge clk);
        #1 start = 1'b0;
        drain(40);

        for (int r = 0; r < 20; r++) begin
            int x, y;
            x = TIMEOUT ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 15));
            y = int'($urandom_range(1, 15));
            run_gcd(x, y, -1, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width of the controlled GCD datapath.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port clr, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a request to compute GCD of the operands currently on the datapath x/y inputs.
REQ-005 The block SHALL have ports eq and lt, input, 1 each, the datapath comparator results (x_reg==y_reg, x_reg<y_reg).
REQ-006 The block SHALL have ports x_load and y_load, output, 1 each, the datapath register load enables.
REQ-007 The block SHALL have ports x_select and y_select, output, 1 each; 1 selects the external operand, 0 selects the difference.
REQ-008 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-009 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 The block SHALL have port err, output, 1, a timeout flag valid with done.
REQ-011 The block SHALL have port iters, output, WIDTH+1, the count of subtraction steps, valid with done.

Function
REQ-012 The block SHALL implement a Moore FSM with states IDLE, LOAD, CMP, SUBX, SUBY, DONE.
REQ-013 In IDLE with start=1 at a rising edge, the FSM SHALL go to LOAD; start SHALL be ignored in every other state.
REQ-014 LOAD SHALL drive x_load=y_load=x_select=y_select=1 for one cycle, clear the iteration counter, then go to CMP.
REQ-015 CMP SHALL drive all four datapath controls 0 and SHALL transition as follows: eq=1 -> DONE; else lt=1 -> SUBY; else -> SUBX.
REQ-016 SUBX SHALL drive x_load=1, x_select=0 (x_reg <= x_reg - y_reg), increment iters, then go to CMP.
REQ-017 SUBY SHALL drive y_load=1, y_select=0 (y_reg <= y_reg - x_reg), increment iters, then go to CMP.
REQ-018 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE; busy SHALL be 1 in DONE.
REQ-019 With k subtractions, done SHALL be high in cycle 2k+3 counting the cycle after the start-accepting edge as cycle 1.
REQ-020 iters and err SHALL hold their values from DONE until the next LOAD.
REQ-021 The iteration counter SHALL saturate at 2**WIDTH and never wrap.

Reset
REQ-022 clr=1 SHALL immediately force IDLE regardless of clock, including mid-computation.
REQ-023 During and after reset, x_load, y_load, x_select, y_select, busy, done and err SHALL all be 0, and iters SHALL be 0.

Configuration
REQ-024 With macro GCD_CTRL_TIMEOUT_EN defined, if iters equals 2**WIDTH in CMP and eq=0, the FSM SHALL go to DONE with err=1.
REQ-025 Without GCD_CTRL_TIMEOUT_EN, err SHALL be tied to 0 and CMP SHALL loop indefinitely on a zero operand.

Structure
REQ-026 The state encoding typedef and the MAX_ITER(WIDTH)=2**WIDTH constant SHALL reside in shared package gcd_pkg.
REQ-027 The saturating iteration counter SHALL be a sub-module, gcd_iter_counter, with clear, increment and saturation output.

Verification
REQ-028 The bench SHALL cover: x=12, y=8, start -> LOAD,CMP,SUBX,CMP,SUBY,CMP,DONE; done in cycle 7, iters=2, err=0.
REQ-029 The bench SHALL cover: x=7, y=7 -> done in cycle 3, iters=0, no load asserted after LOAD.
REQ-030 The bench SHALL cover: x=1, y=15 -> 14 SUBY steps, done in cycle 31, iters=14.
REQ-031 The bench SHALL cover: x=0, y=5 with GCD_CTRL_TIMEOUT_EN -> done in cycle 35, err=1, iters=16; without the macro -> busy still 1 after 100 cycles.
REQ-032 The bench SHALL cover: clr pulse asserted during SUBX -> outputs 0 without a clock edge; a subsequent start restarts from LOAD.
REQ-033 The bench SHALL cover: start held high through a whole computation -> exactly one computation per IDLE visit, with a new LOAD on the cycle after DONE->IDLE.
